// File: rtl/glip_uart_pkg.sv
// Shared definitions for the GLIP UART backend: receiver FSM encoding,
// mid-bit sample offsets and 8N1 frame constants.
package glip_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Three consecutive samples centred on mid-bit; the bit is decided on the last one.
    function automatic int sample_early(input int divisor);
        return divisor / 2 - 1;
    endfunction

    function automatic int sample_mid(input int divisor);
        return divisor / 2;
    endfunction

    function automatic int sample_late(input int divisor);
        return divisor / 2 + 1;
    endfunction

endpackage

// File: rtl/glip_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs with a configurable reset value.
module glip_sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/glip_uart_rx_oversample.sv
// Oversampling 8N1 UART receiver: majority-voted bits, single-entry valid/ready
// output and single-cycle framing/break/overrun pulses.
module glip_uart_rx_oversample
    import glip_uart_pkg::*;
#(
    parameter int DIVISOR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       framing_error,
    output logic       break_detect,
    output logic       overrun
);

    localparam int                   CNT_W    = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0]     S_EARLY  = CNT_W'(sample_early(DIVISOR));
    localparam logic [CNT_W-1:0]     S_MID    = CNT_W'(sample_mid(DIVISOR));
    localparam logic [CNT_W-1:0]     S_LATE   = CNT_W'(sample_late(DIVISOR));
    localparam logic [2:0]           BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic                      rxs;
    uart_rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [1:0]                samp;
    logic                      maj, at_decide, at_wrap;
    logic                      byte_good, byte_ferr, byte_brk;

    glip_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    assign at_decide = (cnt == S_LATE);
    assign at_wrap   = (cnt == CNT_LAST);
    assign maj       = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        byte_good = 1'b0;
        byte_ferr = 1'b0;
        byte_brk  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rxs) state_nxt = ST_START;
            end
            ST_START: begin
                if (at_decide && maj) state_nxt = ST_IDLE;
                else if (at_wrap)     state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (at_wrap && bit_idx == BIT_LAST) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // Decided at mid stop bit so the next start edge may come early.
                if (at_decide) begin
                    if (maj) begin
                        byte_good = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        byte_ferr = (shreg != '0);
                        byte_brk  = (shreg == '0);
                        state_nxt = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            samp    <= '0;
        end else begin
            if (state inside {ST_START, ST_DATA, ST_STOP}) begin
                cnt <= at_wrap ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (cnt == S_EARLY) samp[0] <= rxs;
            if (cnt == S_MID)   samp[1] <= rxs;
            if (state == ST_DATA && at_decide) begin
                shreg <= {maj, shreg[UART_DATA_BITS-1:1]};
            end
            if (state == ST_START) begin
                bit_idx <= '0;
            end else if (state == ST_DATA && at_wrap) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // A good byte is dropped only if the held byte is not leaving this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data      <= '0;
            out_valid     <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= byte_ferr;
            break_detect  <= byte_brk;
            overrun       <= byte_good && out_valid && !out_ready;
            if (byte_good && !(out_valid && !out_ready)) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_glip_uart_rx_oversample.sv
// Scoreboard bench for glip_uart_rx_oversample: frames are predicted from their
// line content and checked by an independent output monitor.
module tb_glip_uart_rx_oversample;

    localparam int D = 16;

    typedef enum int { EV_FERR = 1, EV_BRK = 2, EV_OVR = 3 } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       framing_error;
    logic       break_detect;
    logic       overrun;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_data[$];
    int         exp_evt[$];
    int         rdy_mode = 0;

    always #5 clk = ~clk;

    glip_uart_rx_oversample #(.DIVISOR(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .framing_error (framing_error),
        .break_detect  (break_detect),
        .overrun       (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_evt(input string name, input int kind);
        if (exp_evt.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got pulse kind %0d, expected no pulse", name, kind);
        end else begin
            check(name, kind, exp_evt.pop_front());
        end
    endtask

    // Reference model: a stop bit of 1 yields the byte, otherwise an error class.
    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) exp_data.push_back(d);
        else if (d != 8'h00) exp_evt.push_back(EV_FERR);
        else exp_evt.push_back(EV_BRK);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input bit noisy);
        for (int c = 0; c < D; c++) begin
            rx = (noisy && c == D / 2) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int noise_bit,
                              input bit predict);
        if (predict) model_frame(d, stop);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], i == noise_bit);
        drive_bit(stop, 1'b0);
        if (!stop) idle(2 * D);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        logic       pv;
        logic       ph;
        logic [7:0] pd;
        pv = 1'b0;
        ph = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (pv && !ph && out_valid) check("data_stable", out_data, pd);
                if (out_valid && out_ready) begin
                    if (exp_data.size() == 0) begin
                        n_checks++;
                        $display("FAIL rx_byte: got %0h, expected no byte", out_data);
                    end else begin
                        check("rx_byte", out_data, exp_data.pop_front());
                    end
                end
                if (framing_error) check_evt("framing_pulse", EV_FERR);
                if (break_detect)  check_evt("break_pulse", EV_BRK);
                if (overrun)       check_evt("overrun_pulse", EV_OVR);
            end
            pv = out_valid;
            ph = out_valid && out_ready;
            pd = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rx        = 1'b1;
        rst       = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_pulses", {framing_error, break_detect, overrun}, 0);
        rst = 1'b0;
        @(negedge clk);
        rdy_mode = 1;
        idle(4);

        // Nominal frame with first-edge-to-valid latency measurement
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, -1, 1'b1);
            begin
                for (int i = 1; i <= 400; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        n = i;
                        break;
                    end
                end
            end
        join
        check("pin_to_valid_edges", n, 2 + 1 + 154);
        idle(D);

        // Short glitch is a false start, then a normal byte
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * D);
        send_frame(8'h3C, 1'b1, -1, 1'b1);

        // Single-cycle noise inside data bit 3
        send_frame(8'h00, 1'b1, 3, 1'b1);

        // Framing error, then a long break
        send_frame(8'h55, 1'b0, -1, 1'b1);
        model_frame(8'h00, 1'b0);
        rx = 1'b0;
        repeat (12 * D) @(negedge clk);
        idle(2 * D);

        // Overrun: second byte dropped, first kept
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        send_frame(8'h11, 1'b1, -1, 1'b1);
        exp_evt.push_back(EV_OVR);
        send_frame(8'h22, 1'b1, -1, 1'b0);
        #1;
        check("overrun_valid_held", out_valid, 1);
        check("overrun_data_kept", out_data, 8'h11);
        @(negedge clk);
        rdy_mode = 1;
        idle(4);
        check("overrun_drained", out_valid, 0);

        // Reset during data bit 5 while a byte is held
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        check("held_before_reset", out_valid, 1);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midframe_reset_valid", out_valid, 0);
        check("midframe_reset_data", out_data, 0);
        check("midframe_reset_pulses", {framing_error, break_detect, overrun}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rdy_mode = 1;
        idle(2 * D);
        send_frame(8'hF0, 1'b1, -1, 1'b1);

        // Randomized frames with random consumer backpressure
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            logic [7:0] d;
            logic       stop;
            int         nb;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            nb   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(d, stop, nb, 1'b1);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2 * D)));
        end

        rdy_mode = 1;
        idle(4 * D);
        check("pending_bytes", exp_data.size(), 0);
        check("pending_events", exp_evt.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
